pipe_if_stage: RTL and testbench
================================

PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 SHALL have parameter REG_DATA_WIDTH, default 32, PC and instruction width.
REQ-002 SHALL have parameter PC_RESET, default 32'h00000000, first fetch address after reset.
REQ-003 SHALL have port Clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Stall  input  1  load-use stall from hazard detection; hold IF output.
REQ-006 SHALL have port IF_ID_Flush  input  1  redirect request (branch taken or jump).
REQ-007 SHALL have port EX_PC_Branch  input  1  branch taken in EX; selects branch target.
REQ-008 SHALL have port EX_Branch_target  input  REG_DATA_WIDTH  branch target address.
REQ-009 SHALL have port ID_Jump_target  input  REG_DATA_WIDTH  jump target address.
REQ-010 SHALL have port IMEM_addr  output  REG_DATA_WIDTH  instruction memory read address.
REQ-011 SHALL have port IMEM_data  input  32  instruction memory read data, valid one cycle after IMEM_addr.
REQ-012 SHALL have port IF_PC  output  REG_DATA_WIDTH  PC of the instruction on IF_Instruction.
REQ-013 SHALL have port IF_Instruction  output  32  fetched instruction to ID and hazard detection.
REQ-014 SHALL have port IF_Valid  output  1  IF_Instruction is a real fetched instruction, not an inserted NOP.

Function
REQ-015 SHALL hold registers F_PC (address being requested), IF_PC, Hold_instr, and a state in {REFILL, RUN, HOLD}.
REQ-016 SHALL drive IMEM_addr = F_PC combinationally in every state.
REQ-017 REFILL: IF_Instruction = NOP (32'h00000013), IF_Valid = 0; next edge IF_PC <= F_PC, F_PC <= F_PC+4, state <= RUN.
REQ-018 RUN: IF_Instruction = IMEM_data, IF_Valid = 1; with no Stall and no flush, next edge IF_PC <= F_PC, F_PC <= F_PC+4.
REQ-019 RUN with Stall=1 and IF_ID_Flush=0: Hold_instr <= IMEM_data; IF_PC and F_PC unchanged; state <= HOLD.
REQ-020 HOLD: IF_Instruction = Hold_instr, IF_Valid = 1; IMEM_addr stays F_PC; Stall=1 stays in HOLD.
REQ-021 HOLD with Stall=0: IF_PC <= F_PC, F_PC <= F_PC+4, state <= RUN; there SHALL be no bubble.
REQ-022 IF_ID_Flush=1 in any state: F_PC <= (EX_PC_Branch ? EX_Branch_target : ID_Jump_target) with bits [1:0] forced to 0; state <= REFILL.
REQ-023 Flush SHALL take priority over Stall; branch target SHALL take priority over jump target.
REQ-024 Stall SHALL be ignored in REFILL.
REQ-025 Flush asserted in REFILL SHALL restart REFILL at the new target.
REQ-026 Redirect penalty SHALL be exactly one NOP cycle after the flush cycle.
REQ-027 F_PC+4 SHALL wrap modulo 2^REG_DATA_WIDTH; 32'hFFFFFFFC advances to 32'h00000000.
REQ-028 Outputs SHALL depend only on registered state plus IMEM_data; there SHALL be no combinational path from Stall or IF_ID_Flush to any output.

Reset
REQ-029 On Reset=1 the block SHALL set, asynchronously: F_PC = PC_RESET, IF_PC = PC_RESET, Hold_instr = NOP, state = REFILL.
REQ-030 During reset the outputs SHALL be IF_Valid=0, IF_Instruction=NOP, IMEM_addr=PC_RESET.
REQ-031 Reset asserted mid-HOLD or mid-REFILL SHALL discard the held instruction and pending target.

Structure
REQ-032 The NOP constant and the fetch state enum SHALL live in RV32I_definitions.
REQ-033 The block SHALL be a single module with no sub-module; the +4 adder and target mux are inline.

Verification
REQ-034 Reset release, IMEM returns word at addr/4 -> cycle 1 NOP/Valid=0; cycle 2 IF_PC=0; then 4, 8 with one instruction per cycle.
REQ-035 Stall held 3 cycles while IF_PC=8 -> IF_PC=8 and IF_Instruction constant for 3 cycles; the next cycle shows IF_PC=12 with no bubble.
REQ-036 IF_ID_Flush with EX_PC_Branch=1, target 0x100, jump target 0x200 -> IMEM_addr=0x100 next cycle, one NOP, then IF_PC=0x100.
REQ-037 Flush and Stall asserted together in HOLD -> flush wins; REFILL at target; hold contents never reappear.
REQ-038 F_PC=0xFFFFFFFC running -> next IF_PC sequence 0xFFFFFFFC, 0x00000000.
REQ-039 Reset asserted mid-HOLD -> outputs immediately NOP/Valid=0, IMEM_addr=PC_RESET.

Source files
------------

// File: rtl/pipe_if_stage_pkg.sv
// pipe_if_stage_pkg: shared RV32I constants and the fetch-stage state encoding
package RV32I_definitions;
   localparam logic [31:0] NOP = 32'h00000013;
   typedef enum logic [1:0] {REFILL, RUN, HOLD} fetch_state_t;
endpackage

// File: rtl/pipe_if_stage_if.sv
// pipe_if_stage_if: fetch-stage bundle
//   master drives Stall, IF_ID_Flush, EX_PC_Branch, EX_Branch_target, ID_Jump_target, IMEM_data
//   slave (the fetch stage) drives IMEM_addr, IF_PC, IF_Instruction, IF_Valid
interface pipe_if_stage_if #(parameter int REG_DATA_WIDTH = 32);
   logic                      Stall;
   logic                      IF_ID_Flush;
   logic                      EX_PC_Branch;
   logic [REG_DATA_WIDTH-1:0] EX_Branch_target;
   logic [REG_DATA_WIDTH-1:0] ID_Jump_target;
   logic [REG_DATA_WIDTH-1:0] IMEM_addr;
   logic [31:0]               IMEM_data;
   logic [REG_DATA_WIDTH-1:0] IF_PC;
   logic [31:0]               IF_Instruction;
   logic                      IF_Valid;
   modport master (
      output Stall, IF_ID_Flush, EX_PC_Branch, EX_Branch_target, ID_Jump_target, IMEM_data,
      input  IMEM_addr, IF_PC, IF_Instruction, IF_Valid
   );
   modport slave (
      input  Stall, IF_ID_Flush, EX_PC_Branch, EX_Branch_target, ID_Jump_target, IMEM_data,
      output IMEM_addr, IF_PC, IF_Instruction, IF_Valid
   );
endinterface

// File: rtl/pipe_if_stage.sv
// pipe_if_stage: instruction fetch stage with stall hold buffer and one-NOP redirect
//   Clk, Reset (async, active-high); bus.slave carries stall/redirect inputs,
//   the instruction-memory address/data pair, and the IF_PC/IF_Instruction/IF_Valid outputs
module pipe_if_stage
   import RV32I_definitions::*;
#(
   parameter int                        REG_DATA_WIDTH = 32,
   parameter logic [REG_DATA_WIDTH-1:0] PC_RESET       = '0
) (
   input logic Clk,
   input logic Reset,
   pipe_if_stage_if.slave bus
);
   fetch_state_t              state, state_nxt;
   logic [REG_DATA_WIDTH-1:0] f_pc, f_pc_nxt, if_pc, if_pc_nxt, tgt;
   logic [31:0]               hold_instr, hold_nxt;
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= REFILL;
         f_pc       <= PC_RESET;
         if_pc      <= PC_RESET;
         hold_instr <= NOP;
      end else begin
         state      <= state_nxt;
         f_pc       <= f_pc_nxt;
         if_pc      <= if_pc_nxt;
         hold_instr <= hold_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      f_pc_nxt  = f_pc;
      if_pc_nxt = if_pc;
      hold_nxt  = hold_instr;
      tgt       = bus.EX_PC_Branch ? bus.EX_Branch_target : bus.ID_Jump_target;
      if (bus.IF_ID_Flush) begin
         f_pc_nxt  = tgt & ~REG_DATA_WIDTH'(3);
         state_nxt = REFILL;
      end else if (state == RUN && bus.Stall) begin
         // memory keeps returning the next word, so the stalled one is captured here
         hold_nxt  = bus.IMEM_data;
         state_nxt = HOLD;
      end else if (state != HOLD || !bus.Stall) begin
         // F_PC was already presented to memory, so leaving HOLD costs no bubble
         if_pc_nxt = f_pc;
         f_pc_nxt  = f_pc + REG_DATA_WIDTH'(4);
         state_nxt = RUN;
      end
   end
   assign bus.IMEM_addr      = f_pc;
   assign bus.IF_PC          = if_pc;
   assign bus.IF_Valid       = state != REFILL;
   assign bus.IF_Instruction = state == REFILL ? NOP : state == HOLD ? hold_instr : bus.IMEM_data;
endmodule

// File: tb/tb_pipe_if_stage.sv
// tb_pipe_if_stage: scoreboard bench for the fetch stage against a word-index instruction memory
module tb_pipe_if_stage;
   import RV32I_definitions::*;
   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] addr;
   } exp_t;
   typedef struct {
      logic        rs, st, fl, br;
      logic [31:0] bt, jt;
      exp_t        e;
   } stim_t;
   logic Clk = 0, Reset = 1;
   int   checks = 0, failures = 0;
   exp_t sb[$];
   exp_t obs, e;
   pipe_if_stage_if #(.REG_DATA_WIDTH(32)) bus ();
   pipe_if_stage #(.REG_DATA_WIDTH(32), .PC_RESET(32'h0)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
   always #5 Clk = ~Clk;
   function automatic logic [31:0] w(input logic [31:0] a);
      return (a >> 2) ^ 32'h5A00_0000;
   endfunction
   always @(posedge Clk) bus.IMEM_data <= w(bus.IMEM_addr);
   function automatic stim_t S(input logic rs, st, fl, br, input logic [31:0] bt, jt,
                               input logic v, input logic [31:0] pc, ins, addr);
      S.rs = rs; S.st = st; S.fl = fl; S.br = br; S.bt = bt; S.jt = jt;
      S.e = '{v, pc, ins, addr};
   endfunction
   task automatic drive(input stim_t s);
      Reset = s.rs; bus.Stall = s.st; bus.IF_ID_Flush = s.fl; bus.EX_PC_Branch = s.br;
      bus.EX_Branch_target = s.bt; bus.ID_Jump_target = s.jt;
      sb.push_back(s.e);
   endtask
   task automatic test_reset();
      stim_t s[3];
      s = '{S(1,0,0,0,0,0, 0,0,NOP,0), S(1,0,0,0,0,0, 0,0,NOP,0), S(0,0,0,0,0,0, 0,0,NOP,0)};
      foreach (s[i]) begin
         @(negedge Clk); drive(s[i]); #1;
         obs = '{bus.IF_Valid, bus.IF_PC, bus.IF_Instruction, bus.IMEM_addr}; e = sb.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL reset[%0d] got %h want %h", i, obs, e); end
      end
   endtask
   task automatic test_run();
      stim_t s[2];
      s = '{S(0,0,0,0,0,0, 1,0,w(0),4), S(0,0,0,0,0,0, 1,4,w(4),8)};
      foreach (s[i]) begin
         @(negedge Clk); drive(s[i]); #1;
         obs = '{bus.IF_Valid, bus.IF_PC, bus.IF_Instruction, bus.IMEM_addr}; e = sb.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL run[%0d] got %h want %h", i, obs, e); end
      end
   endtask
   task automatic test_stall();
      stim_t s[6];
      s = '{S(0,1,0,0,0,0, 1,8,w(8),12), S(0,1,0,0,0,0, 1,8,w(8),12), S(0,1,0,0,0,0, 1,8,w(8),12),
            S(0,0,0,0,0,0, 1,8,w(8),12), S(0,0,0,0,0,0, 1,12,w(12),16), S(0,0,0,0,0,0, 1,16,w(16),20)};
      foreach (s[i]) begin
         @(negedge Clk); drive(s[i]); #1;
         obs = '{bus.IF_Valid, bus.IF_PC, bus.IF_Instruction, bus.IMEM_addr}; e = sb.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL stall[%0d] got %h want %h", i, obs, e); end
      end
   endtask
   task automatic test_flush_branch();
      stim_t s[7];
      s = '{S(0,0,1,1,32'h100,32'h200, 1,32'h14,w(32'h14),32'h18),
            S(0,0,0,0,0,0,              0,32'h14,NOP,32'h100),
            S(0,0,0,0,0,0,              1,32'h100,w(32'h100),32'h104),
            S(0,0,1,0,32'h100,32'h203,  1,32'h104,w(32'h104),32'h108),
            S(0,1,1,1,32'h302,32'h203,  0,32'h104,NOP,32'h200),
            S(0,1,0,0,0,0,              0,32'h104,NOP,32'h300),
            S(0,0,0,0,0,0,              1,32'h300,w(32'h300),32'h304)};
      foreach (s[i]) begin
         @(negedge Clk); drive(s[i]); #1;
         obs = '{bus.IF_Valid, bus.IF_PC, bus.IF_Instruction, bus.IMEM_addr}; e = sb.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL flush[%0d] got %h want %h", i, obs, e); end
      end
   endtask
   task automatic test_flush_over_stall();
      stim_t s[5];
      s = '{S(0,1,0,0,0,0,             1,32'h304,w(32'h304),32'h308),
            S(0,1,1,0,32'h500,32'h400, 1,32'h304,w(32'h304),32'h308),
            S(0,1,0,0,0,0,             0,32'h304,NOP,32'h400),
            S(0,0,0,0,0,0,             1,32'h400,w(32'h400),32'h404),
            S(0,0,0,0,0,0,             1,32'h404,w(32'h404),32'h408)};
      foreach (s[i]) begin
         @(negedge Clk); drive(s[i]); #1;
         obs = '{bus.IF_Valid, bus.IF_PC, bus.IF_Instruction, bus.IMEM_addr}; e = sb.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL flush_stall[%0d] got %h want %h", i, obs, e); end
      end
   endtask
   task automatic test_wrap();
      stim_t s[5];
      s = '{S(0,0,1,0,0,32'hFFFFFFF8, 1,32'h408,w(32'h408),32'h40C),
            S(0,0,0,0,0,0,            0,32'h408,NOP,32'hFFFFFFF8),
            S(0,0,0,0,0,0,            1,32'hFFFFFFF8,w(32'hFFFFFFF8),32'hFFFFFFFC),
            S(0,0,0,0,0,0,            1,32'hFFFFFFFC,w(32'hFFFFFFFC),0),
            S(0,0,0,0,0,0,            1,0,w(0),4)};
      foreach (s[i]) begin
         @(negedge Clk); drive(s[i]); #1;
         obs = '{bus.IF_Valid, bus.IF_PC, bus.IF_Instruction, bus.IMEM_addr}; e = sb.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL wrap[%0d] got %h want %h", i, obs, e); end
      end
   endtask
   task automatic test_reset_hold();
      stim_t s[7];
      s = '{S(0,1,0,0,0,0, 1,4,w(4),8), S(0,1,0,0,0,0, 1,4,w(4),8),
            S(1,1,0,0,0,0, 0,0,NOP,0),  S(1,1,0,0,0,0, 0,0,NOP,0),
            S(0,0,0,0,0,0, 0,0,NOP,0),  S(0,0,0,0,0,0, 1,0,w(0),4), S(0,0,0,0,0,0, 1,4,w(4),8)};
      foreach (s[i]) begin
         @(negedge Clk); drive(s[i]); #1;
         obs = '{bus.IF_Valid, bus.IF_PC, bus.IF_Instruction, bus.IMEM_addr}; e = sb.pop_front(); checks++;
         if (obs !== e) begin failures++; $display("FAIL reset_hold[%0d] got %h want %h", i, obs, e); end
      end
   endtask
   initial begin
      bus.Stall = 0; bus.IF_ID_Flush = 0; bus.EX_PC_Branch = 0;
      bus.EX_Branch_target = 0; bus.ID_Jump_target = 0;
      test_reset();
      test_run();
      test_stall();
      test_flush_branch();
      test_flush_over_stall();
      test_wrap();
      test_reset_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
